// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default width,
// default reset PC and the NOP instruction word.
package core_pkg;

   localparam int          N_DEFAULT        = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register; keeps pc and pc+4 side by side so both
// change on the same edge. Async active-high reset to RESET_PC.
module pc_reg
   import core_pkg::*;
#(
   parameter int            N        = N_DEFAULT,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] pc_d,
   output logic [N-1:0] pc_q,
   output logic [N-1:0] pc_plus4_q
);

   logic [N-1:0] pc_plus4_d;

   // Wraps modulo 2^N by construction of the N-bit adder.
   always_comb begin
      pc_plus4_d = pc_d + N'(4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         pc_plus4_q <= RESET_PC + N'(4);
      end else if (load) begin
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, hands the word
// to decode over valid/ready. Optional macro IFETCH_MISALIGN_TRAP_EN traps misaligned targets.
module instr_fetch
   import core_pkg::*;
#(
   parameter int            n        = N_DEFAULT,
   parameter logic [n-1:0]  RESET_PC = n'(RESET_PC_DEFAULT)
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [n-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [n-1:0] imem_rdata,
   output logic [n-1:0] instr,
   output logic         instr_valid,
   input  logic         instr_ready,
   input  logic         PCSel,
   input  logic [n-1:0] alu_target,
   output logic [n-1:0] pc,
   output logic [n-1:0] pc_plus4,
   output logic         fault
);

   localparam logic [n-1:0] ALIGN_MASK = ~n'(3);

   fetch_state_e state_q, state_d;
   logic [n-1:0] instr_q, instr_d;
   logic [n-1:0] pc_d, pc_q, pc_plus4_q;
   logic [n-1:0] next_pc_raw;
   logic         pc_load;

   pc_reg #(
      .N        (n),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (pc_load),
      .pc_d       (pc_d),
      .pc_q       (pc_q),
      .pc_plus4_q (pc_plus4_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= n'(NOP_INSTR);
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      pc_load     = 1'b0;
      next_pc_raw = PCSel ? alu_target : pc_plus4_q;
      pc_d        = next_pc_raw & ALIGN_MASK;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = VALID;
            end
         end
         VALID: begin
            if (instr_ready) begin
               pc_load = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
               // The raw target is kept in pc so the trap handler can see it.
               pc_d = next_pc_raw;
               if (next_pc_raw[1:0] != 2'b00) begin
                  state_d = FAULT;
               end else begin
                  state_d = FETCH;
               end
`else
               state_d = FETCH;
`endif
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == VALID);
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign fault = (state_q == FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory/consumer driver feeds random and
// directed traffic, a PC model predicts addresses, a monitor checks outputs.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        PCSel;
   logic [31:0] alu_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;

   instr_fetch #(.n(32), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PCSel       (PCSel),
      .alu_target  (alu_target),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned dly;
      logic [31:0] data;
   } mem_t;

   typedef struct {
      int unsigned hold;
      logic        sel;
      logic [31:0] tgt;
   } cons_t;

   mem_t        mem_plan_q[$];
   cons_t       cons_plan_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   int unsigned exp_len_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   logic        drv_en = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] model_pc;
   logic        model_fault;
   int          hs_count;

   logic        mem_busy, cons_busy;
   int unsigned mem_wait, cons_hold;
   logic [31:0] mem_data, cons_tgt;
   logic        cons_sel;

   logic        req_prev, valid_prev, hs_prev, ack_prev, flt_prev;
   logic [31:0] cur_pc, cur_instr;
   int unsigned req_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference: next PC from the architectural rules; returns {fault, pc}.
   function automatic logic [32:0] model_next(input logic [31:0] cur, input logic sel,
                                              input logic [31:0] tgt);
      logic [31:0] inc;
      inc = cur + 32'd4;
      if (!sel) return {1'b0, inc};
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) return {1'b1, tgt};
      return {1'b0, tgt};
`else
      return {1'b0, tgt & 32'hFFFF_FFFC};
`endif
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
   endfunction

   // Stimulus: memory responder and instruction consumer, driven just after posedge.
   always @(posedge clk) begin
      #1;
      if (drv_en) begin
         if (imem_req) begin
            if (!mem_busy) begin
               mem_busy = 1'b1;
               if (mem_plan_q.size() > 0) begin
                  mem_t me;
                  me       = mem_plan_q.pop_front();
                  mem_wait = me.dly;
                  mem_data = me.data;
               end else begin
                  mem_wait = $urandom_range(0, 3);
                  mem_data = $urandom;
               end
               exp_len_q.push_back(mem_wait + 1);
            end
            if (mem_wait == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_data;
               exp_instr_q.push_back(mem_data);
               mem_busy   = 1'b0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom;
               mem_wait   = mem_wait - 1;
            end
         end else begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
         end

         if (instr_valid) begin
            if (!cons_busy) begin
               cons_busy = 1'b1;
               if (cons_plan_q.size() > 0) begin
                  cons_t ce;
                  ce        = cons_plan_q.pop_front();
                  cons_hold = ce.hold;
                  cons_sel  = ce.sel;
                  cons_tgt  = ce.tgt;
               end else begin
                  cons_hold = $urandom_range(0, 2);
                  cons_sel  = 1'($urandom_range(0, 1));
                  cons_tgt  = rand_target();
               end
            end
            if (cons_hold == 0) begin
               logic [32:0] nx;
               instr_ready = 1'b1;
               PCSel       = cons_sel;
               alu_target  = cons_tgt;
               nx          = model_next(model_pc, cons_sel, cons_tgt);
               model_pc    = nx[31:0];
               model_fault = nx[32];
               if (!nx[32]) exp_addr_q.push_back(nx[31:0]);
               cons_busy   = 1'b0;
               hs_count++;
            end else begin
               instr_ready = 1'b0;
               PCSel       = 1'($urandom_range(0, 1));
               alu_target  = $urandom;
               cons_hold   = cons_hold - 1;
            end
         end else begin
            instr_ready = 1'($urandom_range(0, 1));
            PCSel       = 1'($urandom_range(0, 1));
            alu_target  = $urandom;
         end
      end
   end

   // Monitor: compares DUT outputs against the queued expectations at negedge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (hs_prev) check("redirect_latency", {31'd0, imem_req}, {31'd0, !flt_prev});
         check("fetch_latency", {31'd0, instr_valid && !valid_prev}, {31'd0, ack_prev});
         check("fault", {31'd0, fault}, {31'd0, flt_prev});
         check("req_valid_excl", {31'd0, imem_req && instr_valid}, 32'd0);
         if (flt_prev) check("fault_pc", pc, model_pc);

         if (imem_req && !req_prev) begin
            req_len = 0;
            if (exp_addr_q.size() == 0) fail_now("fetch_addr_underflow");
            else begin
               cur_pc = exp_addr_q.pop_front();
               check("fetch_addr", imem_addr, cur_pc);
            end
         end else if (imem_req) begin
            check("addr_stable", imem_addr, cur_pc);
         end
         if (imem_req) req_len++;
         if (!imem_req && req_prev) begin
            if (exp_len_q.size() == 0) fail_now("req_len_underflow");
            else check("req_len", req_len, exp_len_q.pop_front());
         end

         if (instr_valid && !valid_prev) begin
            if (exp_instr_q.size() == 0) fail_now("instr_underflow");
            else begin
               cur_instr = exp_instr_q.pop_front();
               check("instr", instr, cur_instr);
               check("pc", pc, cur_pc);
               check("pc_plus4", pc_plus4, cur_pc + 32'd4);
            end
         end else if (instr_valid) begin
            check("instr_hold", instr, cur_instr);
            check("pc_hold", pc, cur_pc);
         end

         req_prev   = imem_req;
         valid_prev = instr_valid;
         hs_prev    = instr_valid && instr_ready;
         ack_prev   = imem_req && imem_ack;
         flt_prev   = model_fault;
      end
   end

   task automatic start_run();
      exp_addr_q.delete();
      exp_instr_q.delete();
      exp_len_q.delete();
      model_pc    = RST_PC;
      model_fault = 1'b0;
      mem_busy    = 1'b0;
      cons_busy   = 1'b0;
      hs_count    = 0;
      exp_addr_q.push_back(RST_PC);
      req_prev    = 1'b0;
      valid_prev  = 1'b0;
      hs_prev     = 1'b0;
      ack_prev    = 1'b0;
      flt_prev    = 1'b0;
      cur_pc      = RST_PC;
      cur_instr   = NOP;
      req_len     = 0;
      rst         = 1'b0;
      drv_en      = 1'b1;
      mon_en      = 1'b1;
   endtask

   task automatic wait_hs(input int target, input int budget, input string name);
      int cyc;
      cyc = 0;
      while (hs_count < target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (hs_count < target) fail_now(name);
   endtask

   initial begin
      bit got;
      rst         = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      PCSel       = 1'b0;
      alu_target  = '0;
      model_fault = 1'b0;
      hs_count    = 0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_instr", instr, NOP);
      check("rst_pc", pc, RST_PC);
      check("rst_imem_addr", imem_addr, RST_PC);
      check("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);

      mem_plan_q.push_back('{0, 32'h0000_0033});
      mem_plan_q.push_back('{3, 32'h1234_5678});
      cons_plan_q.push_back('{0, 1'b0, 32'h0});
      cons_plan_q.push_back('{5, 1'b1, 32'h0000_0100});
      cons_plan_q.push_back('{0, 1'b1, 32'hFFFF_FFFC});
      cons_plan_q.push_back('{1, 1'b0, 32'h0});
`ifndef IFETCH_MISALIGN_TRAP_EN
      cons_plan_q.push_back('{0, 1'b1, 32'h0000_0102});
`endif
      start_run();
      wait_hs(200, 6000, "random_run1");

      // Reset in the middle of a fetch with the ack still outstanding.
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (imem_req) got = 1'b1;
      end
      if (!got) fail_now("wait_fetch");
      drv_en   = 1'b0;
      mon_en   = 1'b0;
      imem_ack = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
      check("midrst_pc", pc, RST_PC);
      check("midrst_instr", instr, NOP);
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      check("rst_ack_ignored", instr, NOP);
      check("rst_ack_no_valid", {31'd0, instr_valid}, 32'd0);

      mem_plan_q.delete();
      cons_plan_q.delete();
      mem_plan_q.push_back('{0, 32'h0000_0077});
      start_run();
      wait_hs(40, 1500, "random_run2");

`ifdef IFETCH_MISALIGN_TRAP_EN
      cons_plan_q.push_back('{0, 1'b1, 32'h0000_0102});
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (model_fault) got = 1'b1;
      end
      if (!got) fail_now("wait_trap");
      repeat (6) @(negedge clk);
      check("trap_fault", {31'd0, fault}, 32'd1);
      check("trap_pc", pc, 32'h0000_0102);
      check("trap_no_req", {31'd0, imem_req}, 32'd0);
      check("trap_no_valid", {31'd0, instr_valid}, 32'd0);
`endif

      drv_en = 1'b0;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
